prg_cache_port: RTL and testbench

//  Bridge between the asynchronous NES cartridge bus (PRG/CHR space) and one SDRAM controller port.

---
 rtl/prg_cache_port_if.sv | 34 +++
 rtl/prg_cache_port.sv | 267 ++++++++++++++++++++++++++
 tb/tb_prg_cache_port.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_cache_port_if.sv
// SDRAM controller port seen from the cartridge bridge: request/ack handshake plus data.
interface prg_cache_port_if #(
  parameter int unsigned ADDR_BITS = 23
);
  logic                 ram_req;
  logic                 ram_ack;
  logic                 ram_we;
  logic [ADDR_BITS-2:0] ram_addr;
  logic [1:0]           ram_wm;
  logic [15:0]          ram_wdata;
  logic [15:0]          ram_rdata;

  // Bridge side: issues requests, receives ack and read data.
  modport master (
    output ram_req,
    output ram_we,
    output ram_addr,
    output ram_wm,
    output ram_wdata,
    input  ram_ack,
    input  ram_rdata
  );

  // Controller side.
  modport slave (
    input  ram_req,
    input  ram_we,
    input  ram_addr,
    input  ram_wm,
    input  ram_wdata,
    output ram_ack,
    output ram_rdata
  );
endinterface

// File: rtl/prg_cache_port.sv
// NES cartridge bus to SDRAM port bridge with a small fully associative word cache.
// Writes go through to SDRAM and update a hitting entry; misses on write do not allocate.
// Read hits keep the SDRAM port idle and are offered to the controller as refresh slots.
module prg_cache_port #(
  parameter int unsigned ADDR_BITS   = 23,
  parameter int unsigned LINES       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 oe,
  input  logic                 we,
  input  logic                 flush,
  output logic                 refresh,
  output logic                 busy,
  prg_cache_port_if.master     ram
);

  localparam int unsigned PW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e state_q, state_d;

  // Strobe synchronisers and event pulses
  logic [SYNC_STAGES-1:0] oe_sync_q, we_sync_q;
  logic                   oe_prev_q, we_prev_q;
  logic                   rd_ev_q, wr_ev_q;
  logic [ADDR_BITS-1:0]   addr_q;

  // One-deep read and write slots
  logic                 rdq_q, wrq_q;
  logic [ADDR_BITS-1:0] rdq_addr_q, wrq_addr_q;
  logic [7:0]           wrq_data_q;

  // Cache storage
  logic [LINES-1:0]     valid_q;
  logic [ADDR_BITS-2:0] tag_q  [LINES];
  logic [15:0]          data_q [LINES];
  logic [PW-1:0]        rr_q;
  logic [15:0]          fill_q;

  // SDRAM port registers
  logic                 req_q, req_d;
  logic                 rwe_q, rwe_d;
  logic [ADDR_BITS-2:0] raddr_q, raddr_d;
  logic [1:0]           wm_q, wm_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 refresh_q, refresh_d;

  // Arbitration results
  logic                 srv_rd, srv_wr, take_rd, take_wr;
  logic [ADDR_BITS-1:0] srv_addr;
  logic [7:0]           srv_data;
  logic                 srv_hit, out_hit;
  logic [PW-1:0]        srv_idx, out_idx;
  logic                 fill, wr_upd;
  logic [15:0]          out_word;

  // Synchronise oe/we, detect oe rise and we fall, register the NES address once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_sync_q <= '0;
      we_sync_q <= '0;
      oe_prev_q <= 1'b0;
      we_prev_q <= 1'b0;
      rd_ev_q   <= 1'b0;
      wr_ev_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], oe};
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], we};
      oe_prev_q <= oe_sync_q[SYNC_STAGES-1];
      we_prev_q <= we_sync_q[SYNC_STAGES-1];
      rd_ev_q   <= oe_sync_q[SYNC_STAGES-1] & ~oe_prev_q;
      wr_ev_q   <= ~we_sync_q[SYNC_STAGES-1] & we_prev_q;
      addr_q    <= addr;
    end
  end

  // Pick at most one event to serve in IDLE: queued read, queued write, new read, new write.
  always_comb begin
    srv_rd   = 1'b0;
    srv_wr   = 1'b0;
    take_rd  = 1'b0;
    take_wr  = 1'b0;
    srv_addr = addr_q;
    srv_data = data_in;
    if (state_q == StIdle) begin
      if (rdq_q) begin
        srv_rd   = 1'b1;
        srv_addr = rdq_addr_q;
      end else if (wrq_q) begin
        srv_wr   = 1'b1;
        srv_addr = wrq_addr_q;
        srv_data = wrq_data_q;
      end else if (rd_ev_q) begin
        srv_rd  = 1'b1;
        take_rd = 1'b1;
      end else if (wr_ev_q) begin
        srv_wr  = 1'b1;
        take_wr = 1'b1;
      end
    end
  end

  // Tag lookup for the served event and for the read-data output.
  always_comb begin
    srv_hit = 1'b0;
    srv_idx = '0;
    out_hit = 1'b0;
    out_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && tag_q[i] == srv_addr[ADDR_BITS-1:1]) begin
        srv_hit = 1'b1;
        srv_idx = PW'(i);
      end
      if (valid_q[i] && tag_q[i] == addr_q[ADDR_BITS-1:1]) begin
        out_hit = 1'b1;
        out_idx = PW'(i);
      end
    end
  end

  // Event slots: served slot empties; an event that was not served directly is parked (latest wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdq_q      <= 1'b0;
      wrq_q      <= 1'b0;
      rdq_addr_q <= '0;
      wrq_addr_q <= '0;
      wrq_data_q <= '0;
    end else begin
      if (srv_rd && !take_rd) rdq_q <= 1'b0;
      if (srv_wr && !take_wr) wrq_q <= 1'b0;
      if (rd_ev_q && !take_rd) begin
        rdq_q      <= 1'b1;
        rdq_addr_q <= addr_q;
      end
      if (wr_ev_q && !take_wr) begin
        wrq_q      <= 1'b1;
        wrq_addr_q <= addr_q;
        wrq_data_q <= data_in;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (srv_rd && !srv_hit) state_d = StRdWait;
        else if (srv_wr)        state_d = StWrWait;
      end
      StRdWait, StWrWait: begin
        if (ram.ram_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: SDRAM request fields and refresh slot, held stable while waiting for ack.
  always_comb begin
    req_d     = req_q;
    rwe_d     = rwe_q;
    raddr_d   = raddr_q;
    wm_d      = wm_q;
    wdata_d   = wdata_q;
    refresh_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (srv_rd && srv_hit) begin
          refresh_d = 1'b1;
        end else if (srv_rd) begin
          req_d   = 1'b1;
          rwe_d   = 1'b0;
          raddr_d = srv_addr[ADDR_BITS-1:1];
        end else if (srv_wr) begin
          req_d   = 1'b1;
          rwe_d   = 1'b1;
          raddr_d = srv_addr[ADDR_BITS-1:1];
          // Mask bit set = byte untouched; odd byte address lives in the upper half.
          wm_d    = srv_addr[0] ? 2'b01 : 2'b10;
          wdata_d = {srv_data, srv_data};
        end
      end
      StRdWait, StWrWait: begin
        if (ram.ram_ack) req_d = 1'b0;
      end
      default: req_d = 1'b0;
    endcase
  end

  // SDRAM port and refresh registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      rwe_q     <= 1'b0;
      raddr_q   <= '0;
      wm_q      <= 2'b11;
      wdata_q   <= '0;
      refresh_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      rwe_q     <= rwe_d;
      raddr_q   <= raddr_d;
      wm_q      <= wm_d;
      wdata_q   <= wdata_d;
      refresh_q <= refresh_d;
    end
  end

  assign fill   = (state_q == StRdWait) && ram.ram_ack;
  assign wr_upd = srv_wr && srv_hit;

  // Cache array: write-hit byte update, round-robin fill on read ack, flush of all valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      fill_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_upd) begin
        if (srv_addr[0]) data_q[srv_idx][15:8] <= srv_data;
        else             data_q[srv_idx][7:0]  <= srv_data;
      end
      if (flush) valid_q <= '0;
      if (fill) begin
        tag_q[rr_q]   <= raddr_q;
        data_q[rr_q]  <= ram.ram_rdata;
        // A fill racing a flush is dropped so no stale word survives the flush.
        valid_q[rr_q] <= ~flush;
        fill_q        <= ram.ram_rdata;
        rr_q          <= (rr_q == PW'(LINES - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  // Read data: hitting entry if any, else the most recent fill word.
  always_comb begin
    out_word = out_hit ? data_q[out_idx] : fill_q;
    data_out = addr_q[0] ? out_word[15:8] : out_word[7:0];
  end

  assign refresh       = refresh_q;
  assign busy          = (state_q != StIdle) | rdq_q | wrq_q;
  assign ram.ram_req   = req_q;
  assign ram.ram_we    = rwe_q;
  assign ram.ram_addr  = raddr_q;
  assign ram.ram_wm    = wm_q;
  assign ram.ram_wdata = wdata_q;

endmodule

// File: tb/tb_prg_cache_port.sv
// Directed bench for prg_cache_port with a simple SDRAM responder.
module tb_prg_cache_port;

  localparam int unsigned ADDR_BITS = 23;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [ADDR_BITS-1:0] addr = '0;
  logic [7:0]           data_in = '0;
  logic [7:0]           data_out;
  logic                 oe = 1'b0;
  logic                 we = 1'b1;
  logic                 flush = 1'b0;
  logic                 refresh;
  logic                 busy;

  prg_cache_port_if #(.ADDR_BITS(ADDR_BITS)) ram_if ();

  prg_cache_port #(
    .ADDR_BITS   (ADDR_BITS),
    .LINES       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .oe       (oe),
    .we       (we),
    .flush    (flush),
    .refresh  (refresh),
    .busy     (busy),
    .ram      (ram_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls and request log
  bit          ack_en = 1'b1;
  bit          stray = 1'b0;
  int          ack_delay = 2;
  logic [15:0] rdata_val = '0;
  int          cnt = 0;
  bit          ack_given = 1'b0;
  bit          req_prev = 1'b0;
  int          req_cnt = 0;
  int          refresh_cnt = 0;
  logic        log_we[$];
  logic [21:0] log_addr[$];
  logic [1:0]  log_wm[$];
  logic [15:0] log_wdata[$];

  // SDRAM model: acks a held request after ack_delay cycles when enabled.
  initial begin
    ram_if.ram_ack   = 1'b0;
    ram_if.ram_rdata = '0;
    forever begin
      @(negedge clk);
      ram_if.ram_rdata = rdata_val;
      if (!rst_n || !ram_if.ram_req) begin
        cnt = 0;
        ack_given = 1'b0;
        ram_if.ram_ack = stray;
      end else if (ack_given) begin
        ram_if.ram_ack = 1'b0;
      end else begin
        cnt++;
        if (ack_en && cnt >= ack_delay) begin
          ram_if.ram_ack = 1'b1;
          ack_given = 1'b1;
        end else begin
          ram_if.ram_ack = 1'b0;
        end
      end
    end
  end

  // Log each new request and count refresh slots.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_if.ram_req && !req_prev) begin
        req_cnt++;
        log_we.push_back(ram_if.ram_we);
        log_addr.push_back(ram_if.ram_addr);
        log_wm.push_back(ram_if.ram_wm);
        log_wdata.push_back(ram_if.ram_wdata);
      end
      req_prev = ram_if.ram_req;
      if (refresh) refresh_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      tick(1);
      if (!busy && !ram_if.ram_req) break;
    end
    n_checks++;
    if (i == 300) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b req=%0b still set after 300 cycles, required 0",
               busy, ram_if.ram_req);
    end
    tick(1);
  endtask

  task automatic ev_read(input logic [ADDR_BITS-1:0] a);
    addr = a;
    tick(2);
    oe = 1'b1;
    tick(6);
    oe = 1'b0;
    tick(2);
  endtask

  task automatic ev_write(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
    addr = a;
    data_in = d;
    tick(2);
    we = 1'b0;
    tick(6);
    we = 1'b1;
    tick(2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ram_if.ram_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %0b required 0", ram_if.ram_req);
    end
    n_checks++;
    if (ram_if.ram_wm !== 2'b11) begin
      n_fail++; $display("FAIL reset_wm: got %b required 11", ram_if.ram_wm);
    end
    n_checks++;
    if ({ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus: we/addr/wdata got %0b/%h/%h required 0",
                         ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata);
    end
    n_checks++;
    if ({busy, refresh, data_out} !== 10'h0) begin
      n_fail++; $display("FAIL reset_outs: busy/refresh/data_out got %0b/%0b/%h required 0",
                         busy, refresh, data_out);
    end
  endtask

  task automatic test_read_hit();
    int r0, f0;
    rdata_val = 16'hBEEF;
    r0 = req_cnt;
    ev_read(23'h000010);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 1) begin
      n_fail++; $display("FAIL miss_req_count: got %0d required 1", req_cnt - r0);
    end
    n_checks++;
    if (log_we[$] !== 1'b0 || log_addr[$] !== 22'h000008) begin
      n_fail++; $display("FAIL miss_req_fields: we/addr got %0b/%h required 0/000008",
                         log_we[$], log_addr[$]);
    end
    n_checks++;
    if (data_out !== 8'hEF) begin
      n_fail++; $display("FAIL miss_data: got %h required ef", data_out);
    end
    r0 = req_cnt;
    f0 = refresh_cnt;
    ev_read(23'h000011);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 0 || refresh_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL hit_port: reqs/refresh got %0d/%0d required 0/1",
                         req_cnt - r0, refresh_cnt - f0);
    end
    n_checks++;
    if (data_out !== 8'hBE) begin
      n_fail++; $display("FAIL hit_data: got %h required be", data_out);
    end
  endtask

  task automatic test_evict();
    int r0;
    logic [7:0] exp;
    do_reset();
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      rdata_val = {8'h20 + 8'(i), 8'h40 + 8'(i)};
      ev_read(23'((i + 1) << 8));
      wait_idle();
    end
    n_checks++;
    if (req_cnt - r0 !== 5) begin
      n_fail++; $display("FAIL evict_fills: got %0d reqs required 5", req_cnt - r0);
    end
    r0 = req_cnt;
    for (int i = 2; i < 5; i++) begin
      exp = 8'h40 + 8'(i);
      ev_read(23'((i + 1) << 8));
      wait_idle();
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL evict_hit_data word %0d: got %h required %h", i, data_out, exp);
      end
    end
    n_checks++;
    if (req_cnt - r0 !== 0) begin
      n_fail++; $display("FAIL evict_hits_req: got %0d reqs required 0", req_cnt - r0);
    end
    rdata_val = 16'h7777;
    ev_read(23'h000100);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 1 || log_addr[$] !== 22'h000080) begin
      n_fail++; $display("FAIL evicted_reread: reqs/addr got %0d/%h required 1/000080",
                         req_cnt - r0, log_addr[$]);
    end
    n_checks++;
    if (data_out !== 8'h77) begin
      n_fail++; $display("FAIL evicted_data: got %h required 77", data_out);
    end
  endtask

  task automatic test_write_hit();
    int r0;
    do_reset();
    rdata_val = 16'hBEEF;
    ev_read(23'h000010);
    wait_idle();
    r0 = req_cnt;
    ev_write(23'h000011, 8'h5A);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 1 || log_we[$] !== 1'b1 || log_addr[$] !== 22'h000008) begin
      n_fail++; $display("FAIL wr_req: reqs/we/addr got %0d/%0b/%h required 1/1/000008",
                         req_cnt - r0, log_we[$], log_addr[$]);
    end
    n_checks++;
    if (log_wm[$] !== 2'b01 || log_wdata[$] !== 16'h5A5A) begin
      n_fail++; $display("FAIL wr_fields: wm/wdata got %b/%h required 01/5a5a",
                         log_wm[$], log_wdata[$]);
    end
    r0 = req_cnt;
    ev_read(23'h000011);
    wait_idle();
    n_checks++;
    if (data_out !== 8'h5A || req_cnt - r0 !== 0) begin
      n_fail++; $display("FAIL wr_updated_hi: data/reqs got %h/%0d required 5a/0",
                         data_out, req_cnt - r0);
    end
    ev_read(23'h000010);
    wait_idle();
    n_checks++;
    if (data_out !== 8'hEF) begin
      n_fail++; $display("FAIL wr_untouched_lo: got %h required ef", data_out);
    end
  endtask

  task automatic test_queue_latest();
    int r0;
    do_reset();
    r0 = req_cnt;
    ack_en = 1'b0;
    rdata_val = 16'h3456;
    ev_read(23'h000040);
    ev_write(23'h000041, 8'h11);
    ev_write(23'h000041, 8'h22);
    n_checks++;
    if (busy !== 1'b1 || ram_if.ram_req !== 1'b1 || ram_if.ram_we !== 1'b0
        || ram_if.ram_addr !== 22'h000020) begin
      n_fail++; $display("FAIL q_hold: busy/req/we/addr got %0b/%0b/%0b/%h required 1/1/0/000020",
                         busy, ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr);
    end
    ack_en = 1'b1;
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 2 || log_we[$] !== 1'b1) begin
      n_fail++; $display("FAIL q_one_write: reqs/we got %0d/%0b required 2/1",
                         req_cnt - r0, log_we[$]);
    end
    n_checks++;
    if (log_wdata[$] !== 16'h2222 || log_wm[$] !== 2'b01 || log_addr[$] !== 22'h000020) begin
      n_fail++; $display("FAIL q_latest: wdata/wm/addr got %h/%b/%h required 2222/01/000020",
                         log_wdata[$], log_wm[$], log_addr[$]);
    end
    r0 = req_cnt;
    ev_read(23'h000041);
    wait_idle();
    n_checks++;
    if (data_out !== 8'h22 || req_cnt - r0 !== 0) begin
      n_fail++; $display("FAIL q_coherent_hi: data/reqs got %h/%0d required 22/0",
                         data_out, req_cnt - r0);
    end
    ev_read(23'h000040);
    wait_idle();
    n_checks++;
    if (data_out !== 8'h56) begin
      n_fail++; $display("FAIL q_coherent_lo: got %h required 56", data_out);
    end
  endtask

  task automatic test_simultaneous_flush();
    int r0;
    do_reset();
    r0 = req_cnt;
    rdata_val = 16'hABCD;
    addr = 23'h000060;
    data_in = 8'h99;
    tick(2);
    oe = 1'b1;
    we = 1'b0;
    tick(6);
    oe = 1'b0;
    we = 1'b1;
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 2) begin
      n_fail++; $display("FAIL both_reqs: got %0d required 2", req_cnt - r0);
    end else begin
      n_checks++;
      if (log_we[$-1] !== 1'b0 || log_addr[$-1] !== 22'h000030) begin
        n_fail++; $display("FAIL both_first_read: we/addr got %0b/%h required 0/000030",
                           log_we[$-1], log_addr[$-1]);
      end
      n_checks++;
      if (log_we[$] !== 1'b1 || log_wm[$] !== 2'b10 || log_wdata[$] !== 16'h9999) begin
        n_fail++; $display("FAIL both_then_write: we/wm/wdata got %0b/%b/%h required 1/10/9999",
                           log_we[$], log_wm[$], log_wdata[$]);
      end
    end
    r0 = req_cnt;
    ev_read(23'h000061);
    wait_idle();
    n_checks++;
    if (data_out !== 8'hAB || req_cnt - r0 !== 0) begin
      n_fail++; $display("FAIL both_hit: data/reqs got %h/%0d required ab/0",
                         data_out, req_cnt - r0);
    end
    ev_read(23'h000060);
    wait_idle();
    n_checks++;
    if (data_out !== 8'h99) begin
      n_fail++; $display("FAIL both_lo_updated: got %h required 99", data_out);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    rdata_val = 16'h1357;
    r0 = req_cnt;
    ev_read(23'h000060);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 1 || data_out !== 8'h57) begin
      n_fail++; $display("FAIL flush_miss: reqs/data got %0d/%h required 1/57",
                         req_cnt - r0, data_out);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    do_reset();
    rdata_val = 16'h2468;
    ev_read(23'h000090);
    wait_idle();
    ack_en = 1'b0;
    ev_read(23'h000080);
    n_checks++;
    if (ram_if.ram_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_req_held: got %0b required 1", ram_if.ram_req);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_if.ram_req !== 1'b0 || busy !== 1'b0 || ram_if.ram_wm !== 2'b11) begin
      n_fail++; $display("FAIL mid_async_reset: req/busy/wm got %0b/%0b/%b required 0/0/11",
                         ram_if.ram_req, busy, ram_if.ram_wm);
    end
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(2);
    n_checks++;
    if (ram_if.ram_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: req/busy got %0b/%0b required 0/0",
                         ram_if.ram_req, busy);
    end
    ack_en = 1'b1;
    r0 = req_cnt;
    ev_read(23'h000090);
    wait_idle();
    n_checks++;
    if (req_cnt - r0 !== 1 || data_out !== 8'h68) begin
      n_fail++; $display("FAIL post_reset_miss: reqs/data got %0d/%h required 1/68",
                         req_cnt - r0, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_evict();
    test_write_hit();
    test_queue_latest();
    test_simultaneous_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
